// File: rtl/dp_16x4_arbiter.sv
// Round-robin write arbiter and parity-checked read sequencer in front of a
// 16x4 dual-port EBR with one even-parity bit per word.
module dp_16x4_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] addr_a,
    input  logic [3:0] addr_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    input  logic       rd_req,
    input  logic [3:0] rd_addr,
    output logic       rd_busy,
    output logic       rd_ack,
    output logic [3:0] rd_data,
    output logic       par_err,
    output logic [3:0] err_count,
    output logic       ram_wr_en,
    output logic [3:0] ram_wr_addr,
    output logic [3:0] ram_data,
    output logic       ram_edi,
    output logic       ram_rd_en,
    output logic [3:0] ram_rd_addr,
    input  logic [3:0] ram_q,
    input  logic       ram_edo
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} rd_state_t;

    rd_state_t  state;
    logic       last_b;
    logic       elig_a;
    logic       elig_b;
    logic       win_a;
    logic       win_b;
    logic       win;
    logic [3:0] win_addr;
    logic [3:0] win_data;
    logic [3:0] issue_addr;
    logic       wr_hit;
    logic       collide;

    // A requester granted last cycle sits out one cycle so a held request
    // is not granted twice; the registered grant doubles as that holdoff.
    always_comb begin
        elig_a     = req_a && !gnt_a;
        elig_b     = req_b && !gnt_b;
        win_a      = elig_a && (!elig_b || last_b);
        win_b      = elig_b && !win_a;
        win        = win_a || win_b;
        win_addr   = win_a ? addr_a : addr_b;
        win_data   = win_a ? data_a : data_b;
        issue_addr = (state == IDLE) ? rd_addr : ram_rd_addr;
        wr_hit     = win && (win_addr == issue_addr);
        collide    = ram_wr_en && (ram_wr_addr == ram_rd_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= 4'd0;
            ram_data    <= 4'd0;
            ram_edi     <= 1'b0;
            last_b      <= 1'b1;
        end else begin
            gnt_a     <= win_a;
            gnt_b     <= win_b;
            ram_wr_en <= win;
            if (win) begin
                ram_wr_addr <= win_addr;
                ram_data    <= win_data;
                ram_edi     <= ^win_data;
                last_b      <= win_b;
            end
        end
    end

    // The read enable is registered, so a write that will land on the read
    // address next cycle is predicted here and the issue is held back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= 4'd0;
            rd_busy     <= 1'b0;
            rd_ack      <= 1'b0;
            rd_data     <= 4'd0;
            par_err     <= 1'b0;
            err_count   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack    <= 1'b0;
                    par_err   <= 1'b0;
                    ram_rd_en <= 1'b0;
                    if (rd_req) begin
                        ram_rd_addr <= rd_addr;
                        ram_rd_en   <= !wr_hit;
                        rd_busy     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (collide) begin
                        ram_rd_en <= !wr_hit;
                    end else begin
                        ram_rd_en <= 1'b0;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rd_data <= ram_q;
                    par_err <= (ram_edo != ^ram_q);
                    rd_ack  <= 1'b1;
                    state   <= ACK;
                end
                ACK: begin
                    rd_ack  <= 1'b0;
                    par_err <= 1'b0;
                    rd_busy <= 1'b0;
                    state   <= IDLE;
                    if (par_err && (err_count != 4'd15)) begin
                        err_count <= err_count + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_16x4_arbiter.sv
// Directed bench for dp_16x4_arbiter with a behavioural 16x4 EBR model that
// can invert the parity bit it returns.
module tb_dp_16x4_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [3:0] addr_a, addr_b, data_a, data_b;
    logic       gnt_a, gnt_b;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_busy, rd_ack, par_err;
    logic [3:0] rd_data, err_count;
    logic       ram_wr_en, ram_edi, ram_rd_en, ram_edo;
    logic [3:0] ram_wr_addr, ram_data, ram_rd_addr, ram_q;
    logic       inv_edo;
    logic [3:0] mem [16];
    logic       par_mem [16];
    int         total = 0;
    int         bad = 0;

    dp_16x4_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_busy(rd_busy), .rd_ack(rd_ack), .rd_data(rd_data),
        .par_err(par_err), .err_count(err_count),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_data(ram_data), .ram_edi(ram_edi),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_q(ram_q), .ram_edo(ram_edo)
    );

    always #5 clk = ~clk;

    // Same-edge write and read of one address returns the old word.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr]     <= ram_data;
            par_mem[ram_wr_addr] <= ram_edi;
        end
        if (ram_rd_en) begin
            ram_q   <= mem[ram_rd_addr];
            ram_edo <= par_mem[ram_rd_addr] ^ inv_edo;
        end
    end

    task automatic do_write(input logic sel_b, input logic [3:0] a, input logic [3:0] d);
        if (sel_b) begin req_b = 1'b1; addr_b = a; data_b = d; end
        else begin req_a = 1'b1; addr_a = a; data_a = d; end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] outs;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        outs = {gnt_a, gnt_b, ram_wr_en, ram_wr_addr, ram_data, ram_edi, ram_rd_en,
                ram_rd_addr, rd_busy, rd_ack, rd_data, par_err, err_count, 2'b00};
        total++; if (outs !== 32'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs); end
        total++; if (rd_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", rd_busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write;
        req_a = 1'b1; addr_a = 4'd3; data_a = 4'hA;
        @(negedge clk);
        total++; if ({gnt_a, gnt_b} !== 2'b10) begin bad++; $display("[TB] FAIL single_gnt: got %b expected 10", {gnt_a, gnt_b}); end
        total++; if ({ram_wr_en, ram_wr_addr, ram_data, ram_edi} !== {1'b1, 4'd3, 4'hA, 1'b0}) begin
            bad++; $display("[TB] FAIL single_wrport: got %h expected %h", {ram_wr_en, ram_wr_addr, ram_data, ram_edi}, {1'b1, 4'd3, 4'hA, 1'b0}); end
        req_a = 1'b0;
        @(negedge clk);
        total++; if ({gnt_a, ram_wr_en, ram_wr_addr, ram_data} !== {2'b00, 4'd3, 4'hA}) begin
            bad++; $display("[TB] FAIL single_hold: got %h expected %h", {gnt_a, ram_wr_en, ram_wr_addr, ram_data}, {2'b00, 4'd3, 4'hA}); end
        req_b = 1'b1; addr_b = 4'd9; data_b = 4'h7;
        @(negedge clk);
        total++; if ({gnt_a, gnt_b, ram_wr_addr, ram_data, ram_edi} !== {2'b01, 4'd9, 4'h7, 1'b1}) begin
            bad++; $display("[TB] FAIL single_b: got %h expected %h", {gnt_a, gnt_b, ram_wr_addr, ram_data, ram_edi}, {2'b01, 4'd9, 4'h7, 1'b1}); end
        req_b = 1'b0;
        @(negedge clk);
        // B again with B already last: a lone requester still wins
        req_b = 1'b1; addr_b = 4'd4; data_b = 4'h0;
        @(negedge clk);
        total++; if ({gnt_b, ram_wr_en, ram_wr_addr, ram_edi} !== {2'b11, 4'd4, 1'b0}) begin
            bad++; $display("[TB] FAIL single_b_again: got %h expected %h", {gnt_b, ram_wr_en, ram_wr_addr, ram_edi}, {2'b11, 4'd4, 1'b0}); end
        req_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic exp_b;
        do_write(1'b0, 4'd1, 4'h3);
        req_a = 1'b1; addr_a = 4'd1; data_a = 4'h3;
        req_b = 1'b1; addr_b = 4'd2; data_b = 4'hC;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_b = (i % 2 == 0);
            total++; if ({gnt_a, gnt_b, ram_wr_addr} !== {!exp_b, exp_b, (exp_b ? 4'd2 : 4'd1)}) begin
                bad++; $display("[TB] FAIL rr_grant%0d: got %h expected %h", i, {gnt_a, gnt_b, ram_wr_addr}, {!exp_b, exp_b, (exp_b ? 4'd2 : 4'd1)}); end
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        total++; if ({gnt_a, gnt_b, ram_wr_en} !== 3'b000) begin bad++; $display("[TB] FAIL rr_idle: got %b expected 000", {gnt_a, gnt_b, ram_wr_en}); end
    endtask

    task automatic test_reset_grant;
        req_a = 1'b1; addr_a = 4'd1; data_a = 4'h3;
        @(negedge clk);
        reset = 1'b1; req_a = 1'b0;
        @(negedge clk);
        total++; if ({gnt_a, ram_wr_en} !== 2'b00) begin bad++; $display("[TB] FAIL reset_grant: got %b expected 00", {gnt_a, ram_wr_en}); end
        reset = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        @(negedge clk);
        total++; if ({gnt_a, gnt_b} !== 2'b10) begin bad++; $display("[TB] FAIL reset_last: got %b expected 10", {gnt_a, gnt_b}); end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        do_write(1'b0, 4'd7, 4'h5);
        rd_req = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        total++; if ({rd_busy, ram_rd_en, ram_rd_addr, rd_ack} !== {2'b11, 4'd7, 1'b0}) begin
            bad++; $display("[TB] FAIL read_issue: got %h expected %h", {rd_busy, ram_rd_en, ram_rd_addr, rd_ack}, {2'b11, 4'd7, 1'b0}); end
        rd_addr = 4'd3;
        @(negedge clk);
        total++; if ({rd_ack, ram_rd_en} !== 2'b00) begin bad++; $display("[TB] FAIL read_capture: got %b expected 00", {rd_ack, ram_rd_en}); end
        @(negedge clk);
        total++; if ({rd_ack, rd_data, par_err, rd_busy} !== {1'b1, 4'h5, 2'b01}) begin
            bad++; $display("[TB] FAIL read_ack: got %h expected %h", {rd_ack, rd_data, par_err, rd_busy}, {1'b1, 4'h5, 2'b01}); end
        rd_req = 1'b0;
        @(negedge clk);
        total++; if ({rd_ack, rd_busy} !== 2'b00) begin bad++; $display("[TB] FAIL read_no_queue: got %b expected 00", {rd_ack, rd_busy}); end
        rd_req = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({rd_ack, rd_data, par_err} !== {1'b1, 4'hA, 1'b0}) begin
            bad++; $display("[TB] FAIL read_b2b: got %h expected %h", {rd_ack, rd_data, par_err}, {1'b1, 4'hA, 1'b0}); end
        @(negedge clk);
    endtask

    task automatic test_collision;
        do_write(1'b0, 4'd2, 4'h6);
        req_a = 1'b1; addr_a = 4'd2; data_a = 4'h9;
        rd_req = 1'b1; rd_addr = 4'd2;
        @(negedge clk);
        total++; if ({gnt_a, ram_wr_en, ram_rd_en, rd_busy} !== 4'b1101) begin
            bad++; $display("[TB] FAIL coll_hold: got %b expected 1101", {gnt_a, ram_wr_en, ram_rd_en, rd_busy}); end
        req_a = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        total++; if ({ram_rd_en, ram_wr_en, rd_ack} !== 3'b100) begin
            bad++; $display("[TB] FAIL coll_issue: got %b expected 100", {ram_rd_en, ram_wr_en, rd_ack}); end
        @(negedge clk);
        total++; if (rd_ack !== 1'b0) begin bad++; $display("[TB] FAIL coll_early_ack: got %b expected 0", rd_ack); end
        @(negedge clk);
        total++; if ({rd_ack, rd_data, par_err} !== {1'b1, 4'h9, 1'b0}) begin
            bad++; $display("[TB] FAIL coll_data: got %h expected %h", {rd_ack, rd_data, par_err}, {1'b1, 4'h9, 1'b0}); end
        @(negedge clk);
    endtask

    task automatic test_parity;
        logic [3:0] exp_cnt;
        inv_edo = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rd_req = 1'b1; rd_addr = 4'd7;
            @(negedge clk);
            rd_req = 1'b0;
            repeat (2) @(negedge clk);
            total++; if ({rd_ack, par_err, rd_data} !== {2'b11, 4'h5}) begin
                bad++; $display("[TB] FAIL par_ack%0d: got %h expected %h", i, {rd_ack, par_err, rd_data}, {2'b11, 4'h5}); end
            @(negedge clk);
            exp_cnt = (i < 15) ? 4'(i + 1) : 4'd15;
            total++; if ({err_count, par_err} !== {exp_cnt, 1'b0}) begin
                bad++; $display("[TB] FAIL par_count%0d: got %h expected %h", i, {err_count, par_err}, {exp_cnt, 1'b0}); end
        end
        inv_edo = 1'b0;
    endtask

    task automatic test_reset_mid_read;
        rd_req = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({rd_ack, rd_busy, err_count} !== 6'd0) begin
            bad++; $display("[TB] FAIL reset_read: got %h expected 0", {rd_ack, rd_busy, err_count}); end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++; if ({rd_ack, ram_rd_en} !== 2'b00) begin bad++; $display("[TB] FAIL reset_read_late: got %b expected 00", {rd_ack, ram_rd_en}); end
        end
    endtask

    initial begin
        reset = 1'b1; inv_edo = 1'b0;
        req_a = 1'b0; req_b = 1'b0; addr_a = 4'd0; addr_b = 4'd0; data_a = 4'd0; data_b = 4'd0;
        rd_req = 1'b0; rd_addr = 4'd0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_reset_grant();
        test_read();
        test_collision();
        test_parity();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
